// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared types and constants for the e1of2 node link logic.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int PKT_W = 11;

    localparam logic [PKT_W-1:0] NEUTRAL = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RTZ   = 2'd2
    } tx_state_t;

    // Packet field layout shared with the path-computation logic
    localparam int PKT_DX_LSB  = 0;
    localparam int PKT_DX_W    = 4;
    localparam int PKT_DY_LSB  = 4;
    localparam int PKT_DY_W    = 4;
    localparam int PKT_PLD_LSB = 8;
    localparam int PKT_PLD_W   = 3;

endpackage

`default_nettype wire

// File: rtl/tx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_word_fifo
// Description : Synchronous word FIFO with combinational head output.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_word_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PKT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/e1of2_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : e1of2_sync_tx
// Description : Clocked word source to 4-phase RTZ dual-rail e1of2 channel.
//               Optional timeout flag: define E1OF2_TX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module e1of2_sync_tx
    import noc_pkg::*;
#(
    parameter int PKT_W       = noc_pkg::PKT_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [PKT_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] d_t,
    output logic [PKT_W-1:0] d_f,
    input  logic             e,
    output logic             busy,
    output logic [15:0]      sent_cnt,
    output logic             tx_err
);

    localparam logic [15:0] c_TMO_CYC = 16'(TIMEOUT_CYC);

    tx_state_t              r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [PKT_W-1:0]       r_dt;
    logic [PKT_W-1:0]       r_df;
    logic [15:0]            r_sent;
    logic                   w_es;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [PKT_W-1:0]       w_head;

    // Reset feeds in_ready directly so the source is held off while asserted
    assign in_ready = !w_full && _RESET;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == DRIVE) && !w_es;
    assign w_es     = r_sync[SYNC_STAGES-1];
    assign d_t      = r_dt;
    assign d_f      = r_df;
    assign sent_cnt = r_sent;
    assign busy     = (r_state != IDLE) || !w_empty;

    tx_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (_RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], e};
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_state <= IDLE;
            r_dt    <= '0;
            r_df    <= '0;
            r_sent  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && w_es) begin
                        r_dt    <= w_head;
                        r_df    <= ~w_head;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!w_es) begin
                        r_dt    <= '0;
                        r_df    <= '0;
                        r_sent  <= r_sent + 16'd1;
                        r_state <= RTZ;
                    end
                end
                RTZ: begin
                    if (w_es) begin
                        if (!w_empty) begin
                            r_dt    <= w_head;
                            r_df    <= ~w_head;
                            r_state <= DRIVE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_dt    <= '0;
                    r_df    <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef E1OF2_TX_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_tx_err;

    // Counter saturates so a very long stall cannot wrap back to zero
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_tmo_cnt <= '0;
            r_tx_err  <= 1'b0;
        end else begin
            if (r_state == DRIVE) begin
                if (r_tmo_cnt != 16'hFFFF) r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (r_tmo_cnt == c_TMO_CYC) r_tx_err <= 1'b1;
        end
    end

    assign tx_err = r_tx_err;
`else
    logic [15:0] w_unused_tmo;
    assign w_unused_tmo = c_TMO_CYC;
    assign tx_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_e1of2_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_e1of2_sync_tx
// Description : Scoreboard bench for e1of2_sync_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_e1of2_sync_tx;
    import noc_pkg::*;

    logic               CLK = 1'b0;
    logic               _RESET;
    logic [PKT_W-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [PKT_W-1:0]   d_t;
    logic [PKT_W-1:0]   d_f;
    logic               e;
    logic               busy;
    logic [15:0]        sent_cnt;
    logic               tx_err;

    logic e_man  = 1'b1;
    logic e_auto = 1'b1;
    logic auto   = 1'b0;
    assign e = auto ? e_auto : e_man;

    int n_vec     = 0;
    int n_miss    = 0;
    int n_overlap = 0;

    logic [PKT_W-1:0] exp_q [$];
    logic [PKT_W-1:0] mon_w;
    logic [PKT_W-1:0] mon_wn;
    logic             prev_valid = 1'b0;

    always #5 CLK = ~CLK;

    e1of2_sync_tx #(
        .PKT_W       (PKT_W),
        .DEPTH       (4),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK      (CLK),
        ._RESET   (_RESET),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_t      (d_t),
        .d_f      (d_f),
        .e        (e),
        .busy     (busy),
        .sent_cnt (sent_cnt),
        .tx_err   (tx_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every new token on the rails is popped from the scoreboard
    always @(negedge CLK) begin
        if ((d_t & d_f) != '0) n_overlap++;
        if ((d_t | d_f) != '0 && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got %0h, expected none", d_t);
            end else begin
                mon_w  = exp_q.pop_front();
                mon_wn = ~mon_w;
                check("word_dt", d_t, mon_w);
                check("word_df", d_f, mon_wn);
            end
        end
        prev_valid = ((d_t | d_f) != '0);
    end

    // Receiver model with random ack / re-enable delays
    initial begin
        forever begin
            @(negedge CLK);
            if (auto && _RESET) begin
                if (e_auto && (d_t | d_f) != '0) begin
                    repeat ($urandom_range(0, 7)) @(negedge CLK);
                    e_auto = 1'b0;
                end else if (!e_auto && (d_t | d_f) == '0) begin
                    repeat ($urandom_range(0, 7)) @(negedge CLK);
                    e_auto = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [PKT_W-1:0] w);
        int t = 0;
        @(negedge CLK);
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(w);
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic ack();
        @(negedge CLK);
        e_man = 1'b0;
        repeat (6) @(negedge CLK);
        e_man = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        _RESET = 1'b0;
        repeat (2) @(negedge CLK);
        _RESET = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    initial begin : main
        logic exp_err;
        logic done;
        _RESET   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge CLK);
        check("rst_dt", d_t, NEUTRAL);
        check("rst_df", d_f, NEUTRAL);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sent", sent_cnt, 0);
        check("rst_tx_err", tx_err, 0);
        _RESET = 1'b1;
        repeat (4) @(negedge CLK);

        // Single word with manual ack
        push(11'h5A3);
        check("lat_early_dt", d_t, NEUTRAL);
        @(posedge CLK);
        #1;
        check("lat_dt", d_t, 11'h5A3);
        check("lat_df", d_f, 11'h25C);
        @(negedge CLK);
        e_man = 1'b0;
        repeat (6) @(negedge CLK);
        check("rtz_dt", d_t, NEUTRAL);
        check("rtz_df", d_f, NEUTRAL);
        check("single_sent", sent_cnt, 1);
        check("rtz_busy", busy, 1);
        e_man = 1'b1;
        repeat (6) @(negedge CLK);
        check("idle_busy", busy, 0);
        check("single_drained", exp_q.size(), 0);

        // Back-pressure
        do_reset();
        push(11'h001);
        push(11'h002);
        push(11'h400);
        push(11'h3C5);
        @(negedge CLK);
        check("bp_full_ready", in_ready, 0);
        in_data  = 11'h155;
        in_valid = 1'b1;
        repeat (8) @(negedge CLK);
        check("bp_held_ready", in_ready, 0);
        check("bp_hold_word1", d_t, 11'h001);
        in_valid = 1'b0;
        repeat (4) ack();
        check("bp_sent", sent_cnt, 4);
        check("bp_drained", exp_q.size(), 0);
        check("bp_busy", busy, 0);

        // Push landing on the same edge as the DRIVE->RTZ pop
        do_reset();
        push(11'h111);
        push(11'h222);
        push(11'h333);
        repeat (3) @(negedge CLK);
        check("pp_ready3", in_ready, 1);
        e_man = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        in_data  = 11'h444;
        in_valid = 1'b1;
        exp_q.push_back(11'h444);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        check("pp_popped_same_edge", d_t, NEUTRAL);
        @(negedge CLK);
        check("pp_count_still3", in_ready, 1);
        push(11'h555);
        @(negedge CLK);
        check("pp_count4_full", in_ready, 0);
        e_man = 1'b1;
        repeat (6) @(negedge CLK);
        repeat (4) ack();
        check("pp_sent", sent_cnt, 5);
        check("pp_drained", exp_q.size(), 0);

        // Streaming with a randomly delayed receiver
        do_reset();
        e_auto = 1'b1;
        auto   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push(PKT_W'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge CLK);
        end
        done = 1'b0;
        for (int t = 0; t < 6000 && !done; t++) begin
            @(negedge CLK);
            done = (exp_q.size() == 0) && !busy && e_auto;
        end
        check("stream_drain", done, 1);
        check("stream_sent", sent_cnt, 100);
        auto  = 1'b0;
        e_man = 1'b1;
        repeat (4) @(negedge CLK);

        // Asynchronous reset while a token is on the rails
        do_reset();
        push(11'h0AA);
        repeat (2) @(negedge CLK);
        ack();
        push(11'h7FF);
        repeat (2) @(negedge CLK);
        check("mid_drive_dt", d_t, 11'h7FF);
        check("mid_drive_sent", sent_cnt, 1);
        @(posedge CLK);
        #2 _RESET = 1'b0;
        #1;
        check("async_dt", d_t, NEUTRAL);
        check("async_df", d_f, NEUTRAL);
        check("async_sent", sent_cnt, 0);
        check("async_ready", in_ready, 0);
        repeat (3) @(negedge CLK);
        check("async_ready_held", in_ready, 0);
        _RESET = 1'b1;
        repeat (4) @(negedge CLK);
        check("post_rst_busy", busy, 0);
        check("post_rst_dt", d_t, NEUTRAL);
        check("post_rst_ready", in_ready, 1);

        // Long stall in DRIVE
`ifdef E1OF2_TX_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        push(11'h2B6);
        repeat (40) @(negedge CLK);
        check("tmo_err", tx_err, exp_err);
        ack();
        check("tmo_err_sticky", tx_err, exp_err);
        check("tmo_sent", sent_cnt, 1);
        check("tmo_drained", exp_q.size(), 0);

        check("no_dual_rail", n_overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/e1of2_sync_tx.md
Name: e1of2_sync_tx

Overview:
- Clocked transmitter that turns synchronous 11-bit packet words into a 4-phase, return-to-zero, dual-rail e1of2 channel. Matches the node's 11-bit e1ofN_M(2,11) links.
- Sits between a clocked traffic source (test core, bench driver, FPGA host logic) and a node input port.
- Buffers words in a small FIFO, synchronises the asynchronous enable, and tracks handshake progress.

Parameters:
- PKT_W, 11, packet width in bits; equals the channel M.
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- SYNC_STAGES, 2, flop stages on the enable input; ≥2.
- TIMEOUT_CYC, 1024, cycles in DRIVE before a timeout; used only with the optional feature.

Ports:
- CLK  in  1  system clock.
- _RESET  in  1  asynchronous, active-low reset.
- in_data  in  PKT_W  packet word to send.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept; equals !full.
- d_t  out  PKT_W  true rails; bit i high means data bit i = 1.
- d_f  out  PKT_W  false rails; bit i high means data bit i = 0.
- e  in  1  receiver enable; 1 = ready/neutral seen, 0 = data consumed. Asynchronous.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- sent_cnt  out  16  handshakes completed; wraps at 65535→0.
- tx_err  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset (_RESET=0, asynchronous, mid-operation included):
  - d_t=d_f=0 (neutral) immediately; FIFO emptied; FSM to IDLE.
  - sent_cnt=0, tx_err=0, in_ready=0 while asserted.
  - All synchroniser flops cleared to 0.
  - A token abandoned mid-handshake becomes neutral. Receiver must accept neutral as the end of the cycle.
- Enable synchronisation: e_s = e after SYNC_STAGES flops. All FSM decisions use e_s only.
- Push: when in_valid && in_ready at a CLK edge, the word is written. in_ready is derived from the registered count. No same-cycle pop bypass: when full, in_ready=0 even if a pop happens that cycle.
- FSM states:
  - IDLE: if !empty && e_s==1, register d_t=head, d_f=~head, and go to DRIVE.
  - DRIVE: hold rails. If e_s==0:
    - clear rails to 0;
    - pop FIFO;
    - sent_cnt += 1;
    - go to RTZ.
  - RTZ: hold neutral. If e_s==1: go to DRIVE with the new head if !empty, else go to IDLE.
- Outputs are registered.
  - Latency from push into an empty FIFO (with e_s=1) to rails valid: 2 CLK edges (write, then IDLE→DRIVE).
  - Exactly one rail per bit is high in DRIVE; both rails are 0 otherwise. Both rails high is illegal and must never occur.
- Simultaneous push and pop: both take effect and the count is unchanged.
- Empty FIFO: stays in IDLE with rails neutral.
- Word order: FIFO order preserved; no reordering or drop.
- e glitch: e_s toggling 1→0 while in IDLE or RTZ is ignored.

Optional Feature:
- Macro: E1OF2_TX_TIMEOUT_EN.
- With the macro:
  - a 16-bit counter runs in DRIVE and clears on leaving DRIVE;
  - when it reaches TIMEOUT_CYC, tx_err is set sticky (cleared only by reset);
  - the handshake keeps waiting, so no data is dropped.
- Without the macro: no counter is built and tx_err is tied 0.

Decomposition:
- Shared package noc_pkg:
  - PKT_W=11;
  - NEUTRAL constant (all-zero rails);
  - tx_state_t enum {IDLE, DRIVE, RTZ};
  - packet field constants shared with the path-computation logic.
- One sub-module: tx_word_fifo.
  - Synchronous FIFO, DEPTH words × PKT_W.
  - Ports: push, pop, wdata, rdata (head), full, empty.
  - Asynchronous active-low clear.
- Synchroniser and FSM live in e1of2_sync_tx.

Test Plan:
- Single word, receiver auto-ack:
  - Stimulus: push 11'h5A3 with e=1.
  - Response: rails valid within 2 edges; d_t=11'h5A3, d_f=11'h25C.
  - Stimulus: drop e.
  - Response: rails return to 0; sent_cnt=1; busy falls after e returns to 1.
- Back-pressure:
  - Stimulus: hold e=1, never acknowledge; push 5 words with DEPTH=4.
  - Response: in_ready=0 after the 4th accepted word; the 5th is held by the source. Rails stay on word 1.
  - Stimulus: ack 4 times.
  - Response: words 1–4 emitted in order; sent_cnt=4.
- Streaming:
  - Stimulus: 100 random words; receiver acks with random 0–7 cycle delays.
  - Response: received sequence equals the sent sequence; sent_cnt=100; no cycle with d_t&d_f≠0.
- Reset mid-DRIVE:
  - Stimulus: pull _RESET low while rails hold 11'h7FF.
  - Response: rails go to 0 without a CLK edge; sent_cnt=0; in_ready=0 until release.
  - After release with empty FIFO: IDLE, neutral rails.
- Simultaneous push/pop:
  - Stimulus: FIFO at 3 words; a push lands in the same cycle as the DRIVE→RTZ pop.
  - Response: count stays 3; order preserved.
- Timeout (E1OF2_TX_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: hold e=1 through DRIVE.
  - Response: tx_err=1 at cycle 16 and stays 1 after a later ack.
  - Response: word still delivered; sent_cnt increments.
